// File: rtl/test_stream_gen_pkg.sv
// Shared types and constants for the test stream generator and its pattern helper.
package test_stream_pkg;

  typedef enum logic [1:0] {
    MODE_INCR  = 2'd0,
    MODE_CONST = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_WALK1 = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Feedback taps of the 8-bit LFSR: bits 7, 5, 4 and 3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/test_stream_gen_if.sv
// 8-bit AXI-Stream bundle used between the generator and its downstream slave.
interface test_stream_gen_if;
  logic       tvalid;
  logic       tready;
  logic [7:0] tdata;
  logic       tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/test_stream_gen_pattern_next.sv
// Pattern value generator: produces the first beat of a packet when load is
// high, otherwise the value that follows cur in the selected pattern.
module test_pattern_next
  import test_stream_pkg::*;
(
  input  mode_e      mode,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic [7:0] cur,
  output logic [7:0] nxt
);

  // First value on load, pattern advance otherwise; all arithmetic wraps mod 256.
  always_comb begin
    nxt = cur;
    if (load) begin
      case (mode)
        MODE_INCR:  nxt = seed;
        MODE_CONST: nxt = seed;
        MODE_LFSR:  nxt = (seed == 8'h00) ? 8'h01 : seed;
        MODE_WALK1: nxt = 8'h01;
        default:    nxt = seed;
      endcase
    end else begin
      case (mode)
        MODE_INCR:  nxt = cur + 8'd1;
        MODE_CONST: nxt = cur;
        MODE_LFSR:  nxt = {cur[6:0], ^(cur & LFSR_TAPS)};
        MODE_WALK1: nxt = {cur[6:0], cur[7]};
        default:    nxt = cur;
      endcase
    end
  end

endmodule

// File: rtl/test_stream_gen.sv
// AXI-Stream test packet source: one packet of length+1 generated beats per
// accepted start, with a running XOR checksum of the transferred beats.
module test_stream_gen
  import test_stream_pkg::*;
#(
  parameter int LEN_WIDTH = 8
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [7:0]           seed,
  input  logic [LEN_WIDTH-1:0] length,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           checksum,
  test_stream_gen_if.master    m_axis
);

  state_e               state;
  state_e               state_nxt;
  mode_e                pkt_mode;
  logic [LEN_WIDTH-1:0] pkt_length;
  logic [LEN_WIDTH-1:0] beat_cnt;
  logic [7:0]           beat_data;
  logic [7:0]           checksum_q;
  logic [7:0]           pattern_nxt;
  mode_e                pattern_mode;
  logic                 accept;
  logic                 xfer;
  logic                 is_last;

  // tvalid comes purely from the state register, so it never looks at tready.
  assign accept  = (state == ST_IDLE) && start;
  assign xfer    = (state == ST_SEND) && m_axis.tready;
  assign is_last = (beat_cnt == pkt_length);

  assign m_axis.tvalid = (state == ST_SEND);
  assign m_axis.tlast  = (state == ST_SEND) && is_last;
  assign m_axis.tdata  = beat_data;
  assign busy          = (state != ST_IDLE);
  assign done          = (state == ST_DONE);
  assign checksum      = checksum_q;

  // On an accepted start the live mode input selects the first value.
  assign pattern_mode = accept ? mode_e'(mode) : pkt_mode;

  test_pattern_next u_pattern_next (
    .mode (pattern_mode),
    .load (accept),
    .seed (seed),
    .cur  (beat_data),
    .nxt  (pattern_nxt)
  );

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; start outside IDLE is simply ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_SEND;
      ST_SEND: if (xfer && is_last) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Packet datapath: capture on start, advance beat, counter and checksum on each handshake.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_mode   <= MODE_INCR;
      pkt_length <= '0;
      beat_cnt   <= '0;
      beat_data  <= 8'h00;
      checksum_q <= 8'h00;
    end else if (accept) begin
      pkt_mode   <= mode_e'(mode);
      pkt_length <= length;
      beat_cnt   <= '0;
      beat_data  <= pattern_nxt;
      checksum_q <= 8'h00;
    end else if (xfer) begin
      beat_cnt   <= beat_cnt + 1'b1;
      beat_data  <= pattern_nxt;
      checksum_q <= checksum_q ^ beat_data;
    end
  end

endmodule

// File: tb/tb_test_stream_gen.sv
// Directed bench for test_stream_gen: each task runs one scenario and checks
// beats, tlast, done/busy timing and checksum against hand-computed values.
module tb_test_stream_gen;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic       start;
  logic [1:0] mode;
  logic [7:0] seed;
  logic [7:0] length;
  logic       busy;
  logic       done;
  logic [7:0] checksum;

  int checks = 0;
  int errors = 0;

  logic [7:0] beat_q[$];
  logic       last_q[$];
  int         done_cnt;
  int         stall_err;
  int         done_sample;
  bit         timed_out;
  logic       first_tvalid, first_busy;
  logic [7:0] first_tdata;
  logic       done_tvalid, done_busy;
  logic [7:0] done_checksum;
  logic       idle_busy, idle_tvalid;

  test_stream_gen_if m_axis ();

  test_stream_gen #(.LEN_WIDTH(8)) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .start    (start),
    .mode     (mode),
    .seed     (seed),
    .length   (length),
    .busy     (busy),
    .done     (done),
    .checksum (checksum),
    .m_axis   (m_axis)
  );

  always #5 aclk = ~aclk;

  // Issues one start, then records every handshake until done plus one idle cycle.
  task automatic send_packet(input logic [1:0] m, input logic [7:0] s, input logic [7:0] len,
                             input bit rand_ready, input int restart_at);
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;
    bit         seen_done;
    int         cyc;
    beat_q.delete();
    last_q.delete();
    done_cnt = 0; stall_err = 0; timed_out = 0; seen_done = 0;
    prev_stall = 0; prev_data = 8'h00; prev_last = 0;
    mode = m; seed = s; length = len; start = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0; mode = ~m; seed = ~s; length = len ^ 8'h05;
    first_tvalid = m_axis.tvalid; first_busy = busy; first_tdata = m_axis.tdata;
    cyc = 0;
    while (!seen_done) begin
      if (cyc >= 3000) begin
        timed_out = 1;
        break;
      end
      m_axis.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      start = (cyc == restart_at);
      if (prev_stall && (m_axis.tdata !== prev_data || m_axis.tlast !== prev_last)) stall_err++;
      if (m_axis.tvalid && m_axis.tready) begin
        beat_q.push_back(m_axis.tdata);
        last_q.push_back(m_axis.tlast);
      end
      prev_stall = m_axis.tvalid && !m_axis.tready;
      prev_data  = m_axis.tdata;
      prev_last  = m_axis.tlast;
      if (done) begin
        done_cnt++;
        seen_done     = 1;
        done_tvalid   = m_axis.tvalid;
        done_busy     = busy;
        done_checksum = checksum;
        done_sample   = cyc;
      end
      @(posedge aclk); #1;
      cyc++;
    end
    start = 1'b0;
    if (done) done_cnt++;
    idle_busy   = busy;
    idle_tvalid = m_axis.tvalid;
  endtask

  task automatic test_reset;
    aresetn = 1'b0; start = 1'b1; mode = 2'd0; seed = 8'h33; length = 8'd3;
    m_axis.tready = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    checks++; if (m_axis.tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tvalid got %0b exp 0", m_axis.tvalid); end
    checks++; if (m_axis.tlast !== 1'b0) begin errors++; $display("[TB] FAIL reset_tlast got %0b exp 0", m_axis.tlast); end
    checks++; if (m_axis.tdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_tdata got %02h exp 00", m_axis.tdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %0b exp 0", done); end
    checks++; if (checksum !== 8'h00) begin errors++; $display("[TB] FAIL reset_checksum got %02h exp 00", checksum); end
    start = 1'b0; aresetn = 1'b1;
    @(posedge aclk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_release_idle busy got %0b exp 0", busy); end
  endtask

  task automatic test_incr;
    logic [7:0] exp_d [3];
    exp_d = '{8'h10, 8'h11, 8'h12};
    send_packet(2'd0, 8'h10, 8'd2, 0, -1);
    checks++; if (timed_out) begin errors++; $display("[TB] FAIL incr_timeout got 1 exp 0"); end
    checks++; if (first_tvalid !== 1'b1 || first_busy !== 1'b1 || first_tdata !== 8'h10) begin
      errors++; $display("[TB] FAIL incr_first_cycle got v=%0b b=%0b d=%02h exp v=1 b=1 d=10", first_tvalid, first_busy, first_tdata); end
    checks++; if (beat_q.size() != 3) begin errors++; $display("[TB] FAIL incr_beats got %0d exp 3", beat_q.size()); end
    for (int i = 0; i < 3 && i < beat_q.size(); i++) begin
      checks++; if (beat_q[i] !== exp_d[i] || last_q[i] !== (i == 2)) begin
        errors++; $display("[TB] FAIL incr_beat%0d got %02h/%0b exp %02h/%0b", i, beat_q[i], last_q[i], exp_d[i], i == 2); end
    end
    checks++; if (done_sample != 3) begin errors++; $display("[TB] FAIL incr_done_cycle got %0d exp 3", done_sample); end
    checks++; if (done_tvalid !== 1'b0 || done_busy !== 1'b1) begin
      errors++; $display("[TB] FAIL incr_done_state got v=%0b b=%0b exp v=0 b=1", done_tvalid, done_busy); end
    checks++; if (done_checksum !== 8'h13) begin errors++; $display("[TB] FAIL incr_checksum got %02h exp 13", done_checksum); end
    checks++; if (done_cnt != 1 || idle_busy !== 1'b0) begin
      errors++; $display("[TB] FAIL incr_done_pulse got cnt=%0d busy=%0b exp cnt=1 busy=0", done_cnt, idle_busy); end
    checks++; if (checksum !== 8'h13) begin errors++; $display("[TB] FAIL incr_checksum_hold got %02h exp 13", checksum); end
  endtask

  task automatic test_incr_wrap;
    logic [7:0] exp_d [4];
    exp_d = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    send_packet(2'd0, 8'hFE, 8'd3, 0, -1);
    checks++; if (beat_q.size() != 4) begin errors++; $display("[TB] FAIL wrap_beats got %0d exp 4", beat_q.size()); end
    for (int i = 0; i < 4 && i < beat_q.size(); i++) begin
      checks++; if (beat_q[i] !== exp_d[i]) begin errors++; $display("[TB] FAIL wrap_beat%0d got %02h exp %02h", i, beat_q[i], exp_d[i]); end
    end
    checks++; if (done_checksum !== 8'h00) begin errors++; $display("[TB] FAIL wrap_checksum got %02h exp 00", done_checksum); end
  endtask

  task automatic test_lfsr;
    logic [7:0] exp_d [5];
    exp_d = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
    send_packet(2'd2, 8'h00, 8'd4, 0, -1);
    checks++; if (beat_q.size() != 5) begin errors++; $display("[TB] FAIL lfsr_beats got %0d exp 5", beat_q.size()); end
    for (int i = 0; i < 5 && i < beat_q.size(); i++) begin
      checks++; if (beat_q[i] !== exp_d[i] || last_q[i] !== (i == 4)) begin
        errors++; $display("[TB] FAIL lfsr_beat%0d got %02h/%0b exp %02h/%0b", i, beat_q[i], last_q[i], exp_d[i], i == 4); end
    end
    checks++; if (done_checksum !== 8'h1E) begin errors++; $display("[TB] FAIL lfsr_checksum got %02h exp 1e", done_checksum); end
  endtask

  task automatic test_walk1_stall;
    logic [7:0] exp_d [9];
    exp_d = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    send_packet(2'd3, 8'h55, 8'd8, 1, -1);
    checks++; if (timed_out) begin errors++; $display("[TB] FAIL walk1_timeout got 1 exp 0"); end
    checks++; if (beat_q.size() != 9) begin errors++; $display("[TB] FAIL walk1_beats got %0d exp 9", beat_q.size()); end
    for (int i = 0; i < 9 && i < beat_q.size(); i++) begin
      checks++; if (beat_q[i] !== exp_d[i] || last_q[i] !== (i == 8)) begin
        errors++; $display("[TB] FAIL walk1_beat%0d got %02h/%0b exp %02h/%0b", i, beat_q[i], last_q[i], exp_d[i], i == 8); end
    end
    checks++; if (stall_err != 0) begin errors++; $display("[TB] FAIL walk1_stall_stable got %0d changes exp 0", stall_err); end
    checks++; if (done_checksum !== 8'hFE) begin errors++; $display("[TB] FAIL walk1_checksum got %02h exp fe", done_checksum); end
  endtask

  task automatic test_const_restart;
    int bad;
    send_packet(2'd1, 8'hA5, 8'd255, 0, 100);
    bad = 0;
    foreach (beat_q[i]) if (beat_q[i] !== 8'hA5) bad++;
    checks++; if (beat_q.size() != 256) begin errors++; $display("[TB] FAIL const_beats got %0d exp 256", beat_q.size()); end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL const_data got %0d non-a5 beats exp 0", bad); end
    checks++; if (done_checksum !== 8'h00) begin errors++; $display("[TB] FAIL const_checksum got %02h exp 00", done_checksum); end
    checks++; if (done_cnt != 1 || idle_busy !== 1'b0 || idle_tvalid !== 1'b0) begin
      errors++; $display("[TB] FAIL const_single_done got cnt=%0d busy=%0b v=%0b exp 1/0/0", done_cnt, idle_busy, idle_tvalid); end
  endtask

  task automatic test_back_to_back;
    send_packet(2'd0, 8'h10, 8'd0, 0, -1);
    checks++; if (beat_q.size() != 1) begin errors++; $display("[TB] FAIL b2b_beats got %0d exp 1", beat_q.size()); end
    checks++; if (beat_q.size() == 1 && (beat_q[0] !== 8'h10 || last_q[0] !== 1'b1)) begin
      errors++; $display("[TB] FAIL b2b_beat got %02h/%0b exp 10/1", beat_q[0], last_q[0]); end
    checks++; if (done_sample != 1 || done_checksum !== 8'h10) begin
      errors++; $display("[TB] FAIL b2b_done got cyc=%0d cs=%02h exp cyc=1 cs=10", done_sample, done_checksum); end
  endtask

  task automatic test_async_reset;
    m_axis.tready = 1'b1; mode = 2'd0; seed = 8'h20; length = 8'd9; start = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    checks++; if (m_axis.tdata !== 8'h23 || checksum !== 8'h23) begin
      errors++; $display("[TB] FAIL areset_pre got d=%02h cs=%02h exp d=23 cs=23", m_axis.tdata, checksum); end
    #2 aresetn = 1'b0;
    #1;
    checks++; if (m_axis.tvalid !== 1'b0 || busy !== 1'b0 || checksum !== 8'h00) begin
      errors++; $display("[TB] FAIL areset_async got v=%0b b=%0b cs=%02h exp 0/0/00", m_axis.tvalid, busy, checksum); end
    checks++; if (m_axis.tdata !== 8'h00 || m_axis.tlast !== 1'b0 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL areset_outputs got d=%02h l=%0b done=%0b exp 00/0/0", m_axis.tdata, m_axis.tlast, done); end
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    send_packet(2'd0, 8'h40, 8'd1, 0, -1);
    checks++; if (beat_q.size() != 2 || first_tdata !== 8'h40) begin
      errors++; $display("[TB] FAIL areset_fresh got n=%0d first=%02h exp n=2 first=40", beat_q.size(), first_tdata); end
    checks++; if (done_checksum !== 8'h01) begin errors++; $display("[TB] FAIL areset_checksum got %02h exp 01", done_checksum); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout exp completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_incr();
    test_incr_wrap();
    test_lfsr();
    test_walk1_stall();
    test_const_restart();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
